// File: rtl/sys_tri_root_pkg.sv
// Shared types and math helpers for the triangular-root block (packages sys_pkg_type, sys_pkg_math).
// Latency: none (types and functions only).
// Backpressure: not applicable.
package sys_pkg_type;

  typedef logic [31:0] u32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2,
    DONE = 2'd3
  } sys_tri_root_st_e;

  typedef struct packed {
    u32 n;
    u32 r;
  } tri_res_t;

endpackage

package sys_pkg_math;
  import sys_pkg_type::*;

  // Number of sqrt iterations needed to cover the (W+3)-bit radicand 8x+1.
  function automatic int tri_root_iter(input int w);
    return (w + 4) / 2;
  endfunction

  // n*(n+1)/2 at 64 bits, never overflows for 32-bit n.
  function automatic logic [63:0] sum_arith_seq(input u32 n);
    logic [63:0] nn;
    nn = {32'h0, n};
    return (nn * (nn + 64'd1)) >> 1;
  endfunction

  // Reference inverse for benches: walk n upward until the next triangle exceeds x.
  function automatic tri_res_t tri_root(input u32 x);
    tri_res_t res;
    res = '0;
    for (int k = 1; k <= 100000; k++) begin
      if (sum_arith_seq(u32'(k)) > {32'h0, x}) break;
      res.n = u32'(k);
    end
    res.r = x - u32'(sum_arith_seq(res.n));
    return res;
  endfunction

endpackage

// File: rtl/sys_tri_root_isqrt_step.sv
// One restoring integer-sqrt step: (q, s, pair) -> (q', s').
// Latency: combinational.
// Backpressure: none; the caller decides when to register the result.
module sys_isqrt_step #(
  parameter int SW = 18
) (
  input  logic [SW:0]   q,
  input  logic [SW-1:0] s,
  input  logic [1:0]    pair,
  output logic [SW:0]   q_nxt,
  output logic [SW-1:0] s_nxt
);

  logic [SW+1:0] a;
  logic [SW+1:0] b;
  logic [SW+1:0] t;

  // Trial subtract; the sign bit of t decides between accepting the new root bit and restoring.
  // The remainder invariant q <= 2s keeps every operand inside SW+2 bits.
  always_comb begin
    a     = (SW+2)'({q, pair});
    b     = {s, 2'b01};
    t     = a - b;
    q_nxt = t[SW+1] ? (SW+1)'(a) : (SW+1)'(t);
    s_nxt = (s << 1) | SW'(!t[SW+1]);
  end

endmodule

// File: rtl/sys_tri_root.sv
// Largest n with n(n+1)/2 <= x plus remainder r, via isqrt(8x+1); optional SVA under SYS_TRI_ROOT_ASSERT_EN.
// Latency: out_vld high ITER+2 cycles after accept; one result per ITER+3 cycles.
// Backpressure: in_rdy only in IDLE; result held in DONE until out_rdy.
module sys_tri_root
  import sys_pkg_type::*;
  import sys_pkg_math::*;
#(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_vld,
  output logic           in_rdy,
  input  logic [W-1:0]   in_x,
  output logic           out_vld,
  input  logic           out_rdy,
  output logic [W/2:0]   out_n,
  output logic [W/2:0]   out_r
);

  localparam int SW   = (W + 4) / 2;
  localparam int ITER = tri_root_iter(W);
  localparam int CW   = $clog2(ITER + 1);

  sys_tri_root_st_e state;

  // Radicand padded with one leading zero to an even 2*ITER bits; consumed MSB pair first.
  logic [2*ITER-1:0] rad;
  logic [SW:0]       q;
  logic [SW-1:0]     s;
  logic [CW-1:0]     cnt;

  logic [1:0]        pair;
  logic [SW:0]       q_nxt;
  logic [SW-1:0]     s_nxt;
  logic [SW+2:0]     fin_sum;

  assign pair    = rad[2*ITER-1 -: 2];
  assign in_rdy  = (state == IDLE);
  assign out_vld = (state == DONE);

  sys_isqrt_step #(.SW(SW)) u_step (
    .q     (q),
    .s     (s),
    .pair  (pair),
    .q_nxt (q_nxt),
    .s_nxt (s_nxt)
  );

  // With s = isqrt(8x+1) and q = 8x+1-s^2: odd s gives 8r = q, even s gives 8r = q + 2s - 1.
  assign fin_sum = (SW+3)'(q) + (s[0] ? '0 : (((SW+3)'(s)) << 1) - (SW+3)'(1));

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rad   <= '0;
      q     <= '0;
      s     <= '0;
      cnt   <= '0;
      out_n <= '0;
      out_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_vld) begin
            rad   <= {1'b0, in_x, 3'b001};
            q     <= '0;
            s     <= '0;
            cnt   <= CW'(ITER - 1);
            state <= CALC;
          end
        end
        CALC: begin
          q   <= q_nxt;
          s   <= s_nxt;
          rad <= rad << 2;
          if (cnt == '0) state <= FIN;
          else           cnt   <= cnt - CW'(1);
        end
        FIN: begin
          out_n <= (W/2+1)'((s - SW'(1)) >> 1);
          out_r <= (W/2+1)'(fin_sum >> 3);
          state <= DONE;
        end
        DONE: begin
          if (out_rdy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SYS_TRI_ROOT_ASSERT_EN
  logic [W-1:0]   x_lat;
  logic [2*W-1:0] tri_sum;

  // Capture the accepted operand so the result can be checked against it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               x_lat <= '0;
    else if (in_vld && in_rdy) x_lat <= in_x;
  end

  assign tri_sum = (((2*W)'(out_n) * ((2*W)'(out_n) + (2*W)'(1))) >> 1) + (2*W)'(out_r);

  a_result: assert property (@(posedge clk) disable iff (!rst_n)
    out_vld |-> (tri_sum == (2*W)'(x_lat)) && (out_r <= out_n));

  a_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (out_vld && !out_rdy) |=> ($stable(out_n) && $stable(out_r)));

  a_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(in_rdy && out_vld));

  if ((W % 2) != 0 || W < 4) begin : g_bad_w
    $error("sys_tri_root: W must be even and >= 4");
  end
`endif

endmodule
